// File: rtl/ex_mem_elastic_pkg.sv
// Shared widths, constants and occupancy encoding for the
// EX->MEM elastic pipeline boundary.
package ex_mem_elastic_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef logic [DATA_W_DEF-1:0]     RegBus;
    typedef logic [REG_ADDR_W_DEF-1:0] RegAddrBus;

    localparam RegBus     ZeroWord     = '0;
    localparam RegAddrBus NOPRegAddr   = '0;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // wd, wreg, wdata, hi, lo, whilo, aluop, mem_addr, reg2
    function automatic int payload_w(input int dw, input int aw, input int ow);
        return aw + 2 + 5 * dw + ow;
    endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One payload register of the EX->MEM boundary with load enable
// and synchronous clear.
module ex_mem_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_mem_elastic.sv
// Elastic EX->MEM boundary: valid/ready on both sides, optional skid
// entry, synchronous flush and a holding path for multi-cycle EX ops.
module ex_mem_elastic
    import ex_mem_elastic_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int CNT_W      = 2,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic                  ex_hold,
    input  logic [2*DATA_W-1:0]   hilo_temp_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_temp_o,
    output logic [CNT_W-1:0]      cnt_o
);

    localparam int PW = payload_w(DATA_W, REG_ADDR_W, ALUOP_W);

    logic [1:0]          r_occ;
    logic [1:0]          w_occ_nxt;
    logic                w_accept;
    logic                w_retire;
    logic                w_head_ld;
    logic                w_from_skid;
    logic [PW-1:0]       w_in;
    logic [PW-1:0]       w_head_d;
    logic [PW-1:0]       w_head_q;
    logic [PW-1:0]       w_skid_q;
    logic                w_wreg;
    logic                w_whilo;
    logic [2*DATA_W-1:0] r_hilo_temp;
    logic [CNT_W-1:0]    r_cnt;

    assign w_in = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo,
                   ex_whilo, ex_aluop, ex_mem_addr, ex_reg2};

    assign mem_valid = (r_occ != OCC_EMPTY);
    assign w_accept  = ex_valid & ex_ready;
    assign w_retire  = mem_valid & mem_ready;

    always_comb begin
        w_occ_nxt   = r_occ;
        w_head_ld   = 1'b0;
        w_from_skid = 1'b0;
        if (flush) begin
            w_occ_nxt = OCC_EMPTY;
        end else begin
            case (r_occ)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_occ_nxt = OCC_ONE;
                        w_head_ld = 1'b1;
                    end
                end
                OCC_ONE: begin
                    // without a skid slot an accept in ONE always pairs with a retire
                    if (w_accept && (w_retire || SKID == 0)) begin
                        w_head_ld = 1'b1;
                    end else if (w_accept) begin
                        w_occ_nxt = OCC_TWO;
                    end else if (w_retire) begin
                        w_occ_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (w_retire) begin
                        w_occ_nxt   = OCC_ONE;
                        w_head_ld   = 1'b1;
                        w_from_skid = 1'b1;
                    end
                end
                default: w_occ_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    assign w_head_d = w_from_skid ? w_skid_q : w_in;

    ex_mem_slot #(.W(PW)) u_head (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_head_ld),
        .i_clr  (flush),
        .i_d    (w_head_d),
        .o_q    (w_head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_ready;
            logic w_skid_ld;

            assign w_skid_ld = !flush && (r_occ == OCC_ONE)
                             && w_accept && !w_retire;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ready <= 1'b1;
                end else begin
                    r_ready <= (w_occ_nxt != OCC_TWO);
                end
            end

            ex_mem_slot #(.W(PW)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_skid_ld),
                .i_clr  (flush),
                .i_d    (w_in),
                .o_q    (w_skid_q)
            );

            assign ex_ready = r_ready;
        end else begin : g_noskid
            assign w_skid_q = '0;
            assign ex_ready = !mem_valid | mem_ready;
        end
    endgenerate

    assign {mem_wd, w_wreg, mem_wdata, mem_hi, mem_lo,
            w_whilo, mem_aluop, mem_mem_addr, mem_reg2} = w_head_q;

    assign mem_wreg  = mem_valid ? w_wreg  : WriteDisable;
    assign mem_whilo = mem_valid ? w_whilo : WriteDisable;

    // partial product survives only while EX keeps asserting hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hilo_temp <= '0;
            r_cnt       <= '0;
        end else if (flush || !ex_hold) begin
            r_hilo_temp <= '0;
            r_cnt       <= '0;
        end else begin
            r_hilo_temp <= hilo_temp_i;
            r_cnt       <= cnt_i;
        end
    end

    assign hilo_temp_o = r_hilo_temp;
    assign cnt_o       = r_cnt;

endmodule

// File: tb/tb_ex_mem_elastic.sv
// Self-checking bench: SKID=1 and SKID=0 instances on shared inputs,
// scoreboard per instance plus table-driven handshake vectors.
module tb_ex_mem_elastic;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic        ex_whilo;
    logic [7:0]  ex_aluop;
    logic        ex_hold;
    logic [63:0] hilo_temp_i;
    logic [1:0]  cnt_i;
    logic        mem_ready;
    logic        g_whilo;

    logic        ex_ready0, mem_valid0, mem_wreg0, mem_whilo0;
    logic [4:0]  mem_wd0;
    logic [31:0] mem_wdata0, mem_hi0, mem_lo0, mem_mem_addr0, mem_reg20;
    logic [7:0]  mem_aluop0;
    logic [63:0] hilo_temp_o0;
    logic [1:0]  cnt_o0;

    logic        ex_ready1, mem_valid1, mem_wreg1, mem_whilo1;
    logic [4:0]  mem_wd1;
    logic [31:0] mem_wdata1, mem_hi1, mem_lo1, mem_mem_addr1, mem_reg21;
    logic [7:0]  mem_aluop1;
    logic [63:0] hilo_temp_o1;
    logic [1:0]  cnt_o1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    typedef struct {
        logic       v;
        logic [4:0] wd;
        logic       mr;
        logic       fl;
        logic       rdy;
        logic       vld;
        logic [4:0] ewd;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    ex_mem_elastic #(.SKID(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready0),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_hold(ex_hold), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_valid(mem_valid0), .mem_ready(mem_ready),
        .mem_wd(mem_wd0), .mem_wreg(mem_wreg0), .mem_wdata(mem_wdata0),
        .mem_hi(mem_hi0), .mem_lo(mem_lo0), .mem_whilo(mem_whilo0),
        .mem_aluop(mem_aluop0), .mem_mem_addr(mem_mem_addr0),
        .mem_reg2(mem_reg20), .hilo_temp_o(hilo_temp_o0), .cnt_o(cnt_o0)
    );

    ex_mem_elastic #(.SKID(0)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready1),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .ex_hold(ex_hold), .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
        .mem_valid(mem_valid1), .mem_ready(mem_ready),
        .mem_wd(mem_wd1), .mem_wreg(mem_wreg1), .mem_wdata(mem_wdata1),
        .mem_hi(mem_hi1), .mem_lo(mem_lo1), .mem_whilo(mem_whilo1),
        .mem_aluop(mem_aluop1), .mem_mem_addr(mem_mem_addr1),
        .mem_reg2(mem_reg21), .hilo_temp_o(hilo_temp_o1), .cnt_o(cnt_o1)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] wd,
                         input logic mr, input logic fl);
        ex_valid    = v;
        ex_wd       = wd;
        ex_wreg     = 1'b1;
        ex_wdata    = 32'h11 * {27'd0, wd};
        ex_hi       = 32'hA000_0000 | {27'd0, wd};
        ex_lo       = 32'h0500_0000 | {27'd0, wd};
        ex_whilo    = g_whilo;
        ex_aluop    = {3'd0, wd};
        ex_mem_addr = 32'h0000_1000 | {27'd0, wd};
        ex_reg2     = ~(32'h11 * {27'd0, wd});
        mem_ready   = mr;
        flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: retire checked against queue head, accept pushed
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else if (flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (mem_valid0 && mem_ready) begin
                if (q0.size() == 0) begin
                    check("sb0_unexpected_wd", {59'd0, mem_wd0}, 64'hFFFF);
                end else begin
                    e = q0.pop_front();
                    check("sb0_wd_wdata", {27'd0, mem_wd0, mem_wdata0},
                          {27'd0, e.wd, e.wdata});
                    check("sb0_hilo", {mem_hi0, mem_lo0}, {e.hi, e.lo});
                end
            end
            if (mem_valid1 && mem_ready) begin
                if (q1.size() == 0) begin
                    check("sb1_unexpected_wd", {59'd0, mem_wd1}, 64'hFFFF);
                end else begin
                    e = q1.pop_front();
                    check("sb1_wd_wdata", {27'd0, mem_wd1, mem_wdata1},
                          {27'd0, e.wd, e.wdata});
                    check("sb1_hilo", {mem_hi1, mem_lo1}, {e.hi, e.lo});
                end
            end
            e.wd    = ex_wd;
            e.wdata = ex_wdata;
            e.hi    = ex_hi;
            e.lo    = ex_lo;
            if (ex_valid && ex_ready0) q0.push_back(e);
            if (ex_valid && ex_ready1) q1.push_back(e);
        end
    end

    logic [1:0] t6_mr [4];
    logic [1:0] t6_rdy[4];
    logic [1:0] t6_vld[4];
    logic [4:0] t6_wd [4];

    initial begin
        // backpressure, then flush while TWO, then recovery
        tbl[0]  = '{1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[1]  = '{1'b1, 5'd6,  1'b0, 1'b0, 1'b1, 1'b1, 5'd5};
        tbl[2]  = '{1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 5'd5};
        tbl[3]  = '{1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5};
        tbl[4]  = '{1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 5'd6};
        tbl[5]  = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd7};
        tbl[6]  = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[7]  = '{1'b1, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[8]  = '{1'b1, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8};
        tbl[9]  = '{1'b1, 5'd9,  1'b0, 1'b1, 1'b0, 1'b1, 5'd8};
        tbl[10] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[11] = '{1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[12] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd11};
        tbl[13] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd0};

        t6_mr  = '{2'd1, 2'd0, 2'd1, 2'd0};
        t6_rdy = '{2'd1, 2'd0, 2'd1, 2'd0};
        t6_vld = '{2'd0, 2'd1, 2'd1, 2'd1};
        t6_wd  = '{5'd20, 5'd21, 5'd21, 5'd22};

        rst         = 1'b1;
        g_whilo     = 1'b0;
        ex_hold     = 1'b0;
        hilo_temp_i = '0;
        cnt_i       = '0;
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        check("rst_mem_valid", {63'd0, mem_valid0}, 64'd0);
        check("rst_mem_wd", {59'd0, mem_wd0}, 64'd0);
        check("rst_mem_wreg", {63'd0, mem_wreg0}, 64'd0);
        check("rst_hilo_temp", hilo_temp_o0, 64'd0);
        check("rst_cnt", {62'd0, cnt_o0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ex_ready", {63'd0, ex_ready0}, 64'd1);
        tick();

        // streaming
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 1'b1, 1'b0);
            tick();
            check("t1_ex_ready", {63'd0, ex_ready0}, 64'd1);
            check("t1_mem_valid", {63'd0, mem_valid0}, 64'd1);
            check("t1_mem_wd", {59'd0, mem_wd0}, 64'(i));
            check("t1_mem_wdata", {32'd0, mem_wdata0}, 64'(32'h11 * i));
        end
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        check("t1_drained", {63'd0, mem_valid0}, 64'd0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].wd, tbl[i].mr, tbl[i].fl);
            @(negedge clk);
            check("tbl_ex_ready", {63'd0, ex_ready0}, {63'd0, tbl[i].rdy});
            check("tbl_mem_valid", {63'd0, mem_valid0}, {63'd0, tbl[i].vld});
            check("tbl_mem_wreg", {63'd0, mem_wreg0}, {63'd0, tbl[i].vld});
            if (tbl[i].vld)
                check("tbl_mem_wd", {59'd0, mem_wd0}, {59'd0, tbl[i].ewd});
            tick();
        end

        // hold path
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        ex_hold     = 1'b1;
        hilo_temp_i = 64'h0000_0001_FFFF_FFFE;
        cnt_i       = 2'd1;
        tick();
        check("t4_hilo_held", hilo_temp_o0, 64'h0000_0001_FFFF_FFFE);
        check("t4_cnt_held", {62'd0, cnt_o0}, 64'd1);
        ex_hold = 1'b0;
        tick();
        check("t4_hilo_clr", hilo_temp_o0, 64'd0);
        check("t4_cnt_clr", {62'd0, cnt_o0}, 64'd0);
        ex_hold = 1'b1;
        cnt_i   = 2'd3;
        tick();
        check("t4_cnt_reheld", {62'd0, cnt_o0}, 64'd3);
        flush = 1'b1;
        tick();
        check("t4_flush_hilo", hilo_temp_o0, 64'd0);
        check("t4_flush_cnt", {62'd0, cnt_o0}, 64'd0);
        flush   = 1'b0;
        ex_hold = 1'b0;
        tick();

        // SKID=0 instance under toggling mem_ready
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t6_wd[i], t6_mr[i][0], 1'b0);
            @(negedge clk);
            check("t6_ex_ready", {63'd0, ex_ready1}, {63'd0, t6_rdy[i][0]});
            check("t6_mem_valid", {63'd0, mem_valid1}, {63'd0, t6_vld[i][0]});
            tick();
        end
        repeat (4) begin
            drive(1'b0, 5'd0, 1'b1, 1'b0);
            tick();
        end
        check("t6_sb1_empty", 64'(q1.size()), 64'd0);

        // async reset while TWO with whilo set
        g_whilo = 1'b1;
        drive(1'b1, 5'd12, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd13, 1'b0, 1'b0);
        tick();
        check("t5_pre_whilo", {63'd0, mem_whilo0}, 64'd1);
        check("t5_pre_hi", {32'd0, mem_hi0}, 64'hA000_000C);
        check("t5_pre_ready", {63'd0, ex_ready0}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_valid", {63'd0, mem_valid0}, 64'd0);
        check("t5_whilo", {63'd0, mem_whilo0}, 64'd0);
        check("t5_hi_lo", {mem_hi0, mem_lo0}, 64'd0);
        tick();
        rst     = 1'b0;
        g_whilo = 1'b0;
        drive(1'b0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("t5_post_ready", {63'd0, ex_ready0}, 64'd1);
        check("t5_post_valid", {63'd0, mem_valid0}, 64'd0);
        tick();
        check("sb0_empty", 64'(q0.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
